// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants used by the fetch stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_WAIT    = 2'd1,
        FS_DISCARD = 2'd2,
        FS_HOLD    = 2'd3
    } fetch_state_e;

    // PC register load selection
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory port, fetch-to-decode outputs.
// Latency: none (wiring only).
// Backpressure: memory stalls via IMemReady, pipeline stalls via StallF.
interface fetch_stage_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   StallF;
    logic                   PCSrcD;
    logic [ADDR_WIDTH-1:0]  PCBranchD;
    logic                   JumpD;
    logic [ADDR_WIDTH-1:0]  PCJumpD;
    logic                   IMemReq;
    logic [ADDR_WIDTH-1:0]  IMemAddr;
    logic [INSTR_WIDTH-1:0] IMemRdata;
    logic                   IMemReady;
    logic [ADDR_WIDTH-1:0]  PCF;
    logic [ADDR_WIDTH-1:0]  PCPlus4F;
    logic [INSTR_WIDTH-1:0] InstrF;
    logic                   FetchValidF;

    // Fetch stage side
    modport master (
        input  StallF, PCSrcD, PCBranchD, JumpD, PCJumpD, IMemRdata, IMemReady,
        output IMemReq, IMemAddr, PCF, PCPlus4F, InstrF, FetchValidF
    );

    // Environment side (memory, decode, hazard unit)
    modport slave (
        output StallF, PCSrcD, PCBranchD, JumpD, PCJumpD, IMemRdata, IMemReady,
        input  IMemReq, IMemAddr, PCF, PCPlus4F, InstrF, FetchValidF
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold / +4 / load-target mux; targets are word-aligned on load.
// Latency: one clock from sel/target to pc; pc_plus4 is combinational from pc.
// Backpressure: none; PC_HOLD freezes the value.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter int                     ADDR_WIDTH = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  pc_sel_e               sel,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    // Wraps modulo 2^ADDR_WIDTH
    assign pc_plus4 = pc + ADDR_WIDTH'(4);

    // PC update: low two bits are always forced to zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            case (sel)
                PC_INC:  pc <= pc_plus4;
                PC_LOAD: pc <= {target[ADDR_WIDTH-1:2], 2'b00};
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: owns the PC, runs the variable-latency imem handshake, applies redirects/stalls.
// Latency: InstrF combinational from IMemRdata in WAIT, from InstrBuf in HOLD; one instr/clk at zero wait.
// Backpressure: IMemReady=0 holds the request; StallF parks a fetched instruction in InstrBuf.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = ADDR_W,
    parameter int                     INSTR_WIDTH = INSTR_W,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);

    localparam logic [1:0] ST_IDLE    = FS_IDLE;
    localparam logic [1:0] ST_WAIT    = FS_WAIT;
    localparam logic [1:0] ST_DISCARD = FS_DISCARD;
    localparam logic [1:0] ST_HOLD    = FS_HOLD;

    logic [1:0]             state, state_nxt;
    logic [INSTR_WIDTH-1:0] instr_buf, instr_buf_nxt;
    logic [ADDR_WIDTH-1:0]  pend_tgt, pend_tgt_nxt;
    logic [ADDR_WIDTH-1:0]  pc, pc_plus4, pc_tgt, target;
    pc_sel_e                pc_sel;
    logic                   redirect;
    logic                   req, valid;
    logic [INSTR_WIDTH-1:0] instr;

    // Branch beats jump when both resolve in the same cycle
    assign redirect = bus.PCSrcD | bus.JumpD;
    assign target   = bus.PCSrcD ? {bus.PCBranchD[ADDR_WIDTH-1:2], 2'b00}
                                 : {bus.PCJumpD[ADDR_WIDTH-1:2], 2'b00};

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .CLK      (CLK),
        .RST      (RST),
        .sel      (pc_sel),
        .target   (pc_tgt),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    // Next-state, PC selection and output decode; redirect > stall > advance
    always_comb begin
        state_nxt     = state;
        instr_buf_nxt = instr_buf;
        pend_tgt_nxt  = pend_tgt;
        pc_sel        = PC_HOLD;
        pc_tgt        = target;
        req           = 1'b0;
        valid         = 1'b0;
        instr         = INSTR_WIDTH'(MIPS_NOP);
        case (state)
            ST_IDLE: begin
                state_nxt = ST_WAIT;
                if (redirect) pc_sel = PC_LOAD;
            end
            ST_WAIT: begin
                req = 1'b1;
                if (bus.IMemReady) begin
                    if (redirect) begin
                        pc_sel = PC_LOAD;
                    end else begin
                        valid = 1'b1;
                        instr = bus.IMemRdata;
                        if (bus.StallF) begin
                            instr_buf_nxt = bus.IMemRdata;
                            state_nxt     = ST_HOLD;
                        end else begin
                            pc_sel = PC_INC;
                        end
                    end
                end else if (redirect) begin
                    pend_tgt_nxt = target;
                    state_nxt    = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                // Old request must complete before the new address can be issued
                req = 1'b1;
                if (redirect) pend_tgt_nxt = target;
                if (bus.IMemReady) begin
                    pc_tgt    = redirect ? target : pend_tgt;
                    pc_sel    = PC_LOAD;
                    state_nxt = ST_WAIT;
                end
            end
            default: begin
                valid = 1'b1;
                instr = instr_buf;
                if (redirect) begin
                    pc_sel        = PC_LOAD;
                    instr_buf_nxt = INSTR_WIDTH'(MIPS_NOP);
                    state_nxt     = ST_WAIT;
                end else if (!bus.StallF) begin
                    pc_sel    = PC_INC;
                    state_nxt = ST_WAIT;
                end
            end
        endcase
    end

    // Sequencer state and side buffers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            instr_buf <= INSTR_WIDTH'(MIPS_NOP);
            pend_tgt  <= '0;
        end else begin
            state     <= state_nxt;
            instr_buf <= instr_buf_nxt;
            pend_tgt  <= pend_tgt_nxt;
        end
    end

    assign bus.IMemReq     = req;
    assign bus.IMemAddr    = pc;
    assign bus.PCF         = pc;
    assign bus.PCPlus4F    = pc_plus4;
    assign bus.InstrF      = instr;
    assign bus.FetchValidF = valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan steps then randomized traffic against a transaction model.
// Latency: inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
// Backpressure: memory readiness and StallF are driven by the bench.
module tb_fetch_stage;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [31:0] salt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: is a fetch started, is the outstanding one dead, is an instruction parked
    bit          m_started, m_dead, m_held;
    logic [31:0] mpc, mpend, mheld;

    fetch_stage_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Memory returns address + 0x100, scrambled by a per-cycle salt
    assign bus.IMemRdata = (bus.IMemAddr + 32'h100) ^ salt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit rdy, input bit stall, input bit pcsrc,
                          input logic [31:0] br, input bit jmp, input logic [31:0] jt,
                          input logic [31:0] s);
        bus.IMemReady = rdy;
        bus.StallF    = stall;
        bus.PCSrcD    = pcsrc;
        bus.PCBranchD = br;
        bus.JumpD     = jmp;
        bus.PCJumpD   = jt;
        salt          = s;
    endtask

    task automatic model_reset();
        m_started = 0; m_dead = 0; m_held = 0;
        mpc = 32'h0; mpend = 32'h0; mheld = 32'h0;
    endtask

    // One clock: compare all outputs against the model, then advance the model
    task automatic cycle();
        logic [31:0] tgt, rd, exp_instr;
        bit redir, exp_valid, exp_req;
        @(negedge CLK);
        redir     = bus.PCSrcD || bus.JumpD;
        tgt       = (bus.PCSrcD ? bus.PCBranchD : bus.PCJumpD) & 32'hFFFF_FFFC;
        rd        = (mpc + 32'h100) ^ salt;
        exp_req   = m_started && !m_held;
        exp_valid = m_started && (m_held || (!m_dead && bus.IMemReady && !redir));
        exp_instr = m_held ? mheld : (exp_valid ? rd : 32'h0);
        check("pcf",   bus.PCF, mpc);
        check("pcp4",  bus.PCPlus4F, mpc + 32'd4);
        check("addr",  bus.IMemAddr, mpc);
        check("req",   32'(bus.IMemReq), 32'(exp_req));
        check("valid", 32'(bus.FetchValidF), 32'(exp_valid));
        check("instr", bus.InstrF, exp_instr);
        if (!m_started) begin
            m_started = 1;
            if (redir) mpc = tgt;
        end else if (m_held) begin
            if (redir) begin mpc = tgt; m_held = 0; end
            else if (!bus.StallF) begin mpc = mpc + 4; m_held = 0; end
        end else if (m_dead) begin
            if (redir) mpend = tgt;
            if (bus.IMemReady) begin mpc = mpend; m_dead = 0; end
        end else if (bus.IMemReady) begin
            if (redir) mpc = tgt;
            else if (bus.StallF) begin m_held = 1; mheld = rd; end
            else mpc = mpc + 4;
        end else if (redir) begin
            m_dead = 1; mpend = tgt;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_req",   32'(bus.IMemReq), 32'h0);
        check("rst_valid", 32'(bus.FetchValidF), 32'h0);
        check("rst_instr", bus.InstrF, 32'h0);
        check("rst_pcf",   bus.PCF, 32'h0);
        check("rst_addr",  bus.IMemAddr, 32'h0);
        check("rst_pcp4",  bus.PCPlus4F, 32'h4);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge CLK);
        #1;

        // Zero-wait memory: one instruction per clock, PC 0,4,8,C
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("seq_pc",    bus.PCF, 32'(i * 4));
            check("seq_instr", bus.InstrF, 32'(i * 4) + 32'h100);
            cycle();
        end

        // Two wait cycles per access
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 0); cycle(); cycle();
            set_in(1, 0, 0, 0, 0, 0, 0); cycle();
        end

        // Stall while ready: park in HOLD for 3 cycles, then release
        set_in(1, 1, 0, 0, 0, 0, 0);
        cycle(); cycle();
        check("hold_req",   32'(bus.IMemReq), 32'h0);
        check("hold_instr", bus.InstrF, 32'h118);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        check("hold_adv_pc", bus.PCF, 32'h1C);

        // Redirect during wait, then a second redirect in DISCARD wins
        set_in(0, 0, 1, 32'h40, 0, 0, 0); cycle();
        set_in(0, 0, 0, 0, 1, 32'h80, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);      cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);      cycle();
        check("discard_addr", bus.IMemAddr, 32'h80);

        // Branch and jump together: branch wins, misaligned target truncated
        set_in(1, 0, 1, 32'h43, 1, 32'h80, 0); cycle();
        check("both_pc", bus.PCF, 32'h40);

        // Address wrap at the top of the space
        set_in(1, 0, 0, 0, 1, 32'hFFFF_FFFD, 0); cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        #1;
        check("wrap_pcp4", bus.PCPlus4F, 32'h0);
        cycle();
        check("wrap_pc", bus.PCF, 32'h0);

        // Reset in the middle of a WAIT at PC=C, then restart from 0
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        check("pre_rst_pc", bus.PCF, 32'hC);
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] br, jt;
            br = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
            jt = $urandom;
            set_in($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0, br,
                   $urandom_range(0, 7) == 0, jt, $urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined 32-bit MIPS core, directly upstream of the fetch-to-decode pipeline register. It owns the PC, drives the Harvard instruction-memory port with a variable-latency req/ready handshake, and applies decode-stage redirects (branch, jump) and hazard-unit stalls. Its InstrF/PCPlus4F/FetchValidF outputs feed the fetch-to-decode register; that register's CLR is driven from ~FetchValidF.

## Interface
- ADDR_WIDTH, 32: PC and memory address width
- INSTR_WIDTH, 32: instruction width
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0

- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock; reset is asynchronous and active-high
- StallF  in  1  hazard unit: hold current instruction and PC
- PCSrcD  in  1  branch taken, resolved in decode
- PCBranchD  in  ADDR_WIDTH  branch target
- JumpD  in  1  jump in decode
- PCJumpD  in  ADDR_WIDTH  jump target
- IMemReq  out  1  instruction-memory request
- IMemAddr  out  ADDR_WIDTH  request address
- IMemRdata  in  INSTR_WIDTH  read data, valid when IMemReady=1
- IMemReady  in  1  request completes this cycle
- PCF  out  ADDR_WIDTH  current fetch PC
- PCPlus4F  out  ADDR_WIDTH  PCF+4
- InstrF  out  INSTR_WIDTH  fetched instruction (NOP 32'h0 when not valid)
- FetchValidF  out  1  InstrF is a real instruction this cycle

## Operation
- Redirect = PCSrcD | JumpD; target = PCBranchD if PCSrcD, else PCJumpD (PCSrcD wins if both are asserted). Target bits [1:0] are forced to 00.
- Priority at every decision point: reset > redirect > stall > advance.
- Memory protocol: once IMemReq=1, IMemAddr holds until the cycle with IMemReady=1. A request is never withdrawn except by reset.
- States:
  - IDLE
    - Entered from reset; IMemReq=0.
    - Next cycle goes to WAIT. If a redirect is present, PCF<=target first.
  - WAIT
    - IMemReq=1, IMemAddr=PCF.
    - Ready & redirect: data dropped (FetchValidF=0), PCF<=target, stay WAIT.
    - Ready & StallF: InstrF=IMemRdata, FetchValidF=1, InstrBuf<=IMemRdata, go to HOLD, PCF unchanged.
    - Ready otherwise: InstrF=IMemRdata, FetchValidF=1, PCF<=PCF+4, stay WAIT.
    - ~Ready & redirect: PendTgt<=target, go to DISCARD.
    - ~Ready otherwise: stay WAIT.
  - DISCARD
    - IMemReq=1, IMemAddr=old PCF, FetchValidF=0.
    - A new redirect overwrites PendTgt (latest wins).
    - On Ready: PCF<=PendTgt (or the same-cycle redirect target if one is present), go to WAIT.
  - HOLD
    - IMemReq=0, InstrF=InstrBuf, FetchValidF=1.
    - Redirect: PCF<=target, InstrBuf discarded, go to WAIT.
    - Else ~StallF: PCF<=PCF+4, go to WAIT.
    - Else stay HOLD.
- PCPlus4F = PCF+4, modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0.
- In every cycle without FetchValidF=1, InstrF = 32'h0.

## Timing
- Reset values:
  - PCF=RESET_PC, state IDLE, IMemReq=0, IMemAddr=RESET_PC
  - FetchValidF=0, InstrF=0, InstrBuf=0, PendTgt=0
  - PCPlus4F=RESET_PC+4
- First request is issued in the cycle after reset deasserts.
- Latency:
  - InstrF/FetchValidF are combinational from IMemRdata/IMemReady in WAIT, registered (InstrBuf) in HOLD.
  - With zero-wait memory (IMemReady tied high), throughput is one instruction per clock.
  - The redirect penalty is one bubble in the redirect cycle, plus any outstanding memory latency in DISCARD.
- StallF in a cycle with no valid instruction (WAIT & ~Ready, DISCARD) has no effect.
- Reset mid-request: state returns to IDLE immediately. The memory must tolerate the abandoned request.

## Structure
- Shared package mips_pkg holds:
  - fetch state enum (IDLE, WAIT, DISCARD, HOLD)
  - MIPS_NOP = 32'h0000_0000
  - default RESET_PC
  - the address/instruction width constants
- One sub-module, fetch_pc_reg:
  - async-reset PC register with the load mux (hold / +4 / target)
  - instantiated once
  - the FSM and InstrBuf/PendTgt stay in fetch_stage

## Test plan
- Reset, then IMemReady=1 constantly, memory returns addr+32'h100: PCF sequence 0,4,8,C; InstrF 100,104,108,10C; FetchValidF=1 from the first request cycle.
- Memory with 2 wait cycles: FetchValidF=0 for 2 cycles, then 1 for one cycle; IMemAddr stable across waits; PCF advances only on Ready.
- At PCF=8, Ready arrives with StallF=1 for 3 cycles: state HOLD, InstrF held at 108, IMemReq=0, PCF=8; StallF drop leads to PCF=C next cycle.
- PCSrcD=1, PCBranchD=40 during WAIT with 2 wait cycles: DISCARD; old data dropped (FetchValidF=0); next IMemAddr=40. A second redirect JumpD=1, PCJumpD=80 while in DISCARD must give IMemAddr=80.
- PCSrcD=1 and JumpD=1 together with targets 40/80, zero-wait memory: PCF=40, FetchValidF=0 for that cycle. Target 43 must load as 40.
- Assert RST mid-WAIT at PCF=C: IMemReq, FetchValidF and InstrF go to 0 in the same cycle, PCF=0; after release, fetch restarts at 0.
